// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic group: sequencer state encoding and
// the default datapath width used by the ALU and the serial adder.
package arith_pkg;

    localparam int ALU_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add4_if.sv
// Start/ready handshake plus result bus for the bit-serial adder.
// Carries an op_sub request line when SERIAL_ADD4_SUB_EN is defined.
interface serial_add4_if #(parameter int WIDTH = 4);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
`ifdef SERIAL_ADD4_SUB_EN
    logic             op_sub;
`endif
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

`ifdef SERIAL_ADD4_SUB_EN
    modport master (
        output start, a, b, carry_in, op_sub,
        input  ready, busy, done, sum, carry_out, overflow
    );
    modport slave (
        input  start, a, b, carry_in, op_sub,
        output ready, busy, done, sum, carry_out, overflow
    );
`else
    modport master (
        output start, a, b, carry_in,
        input  ready, busy, done, sum, carry_out, overflow
    );
    modport slave (
        input  start, a, b, carry_in,
        output ready, busy, done, sum, carry_out, overflow
    );
`endif

endinterface

// File: rtl/add1.sv
// One-bit full adder built from gate cells; structural twin of the
// single-bit full subtractor slice.
module add1 (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic out,
    output logic carry_out
);

    logic p;
    logic g;
    logic t;

    // Propagate/generate form: carry_out = g | (p & carry_in) is the majority function.
    xor2 u_xor_p   (.a(a),   .b(b),        .y(p));
    xor2 u_xor_sum (.a(p),   .b(carry_in), .y(out));
    and2 u_and_g   (.a(a),   .b(b),        .y(g));
    and2 u_and_t   (.a(p),   .b(carry_in), .y(t));
    or2  u_or_c    (.a(g),   .b(t),        .y(carry_out));

endmodule

// File: rtl/and2.sv
// Two-input AND gate cell.
module and2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

// File: rtl/or2.sv
// Two-input OR gate cell.
module or2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

// File: rtl/xor2.sv
// Two-input XOR gate cell.
module xor2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

// File: rtl/serial_add4.sv
// Bit-serial ripple adder: one add1 slice plus a carry flop, LSB first over
// WIDTH cycles. Define SERIAL_ADD4_SUB_EN to add the op_sub (a-b) mode.
module serial_add4
    import arith_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 3
) (
    input logic         clk,
    input logic         rst_n,
    serial_add4_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic               carry_ff;
    logic               msb_cin;
    logic               sub_ff;
    logic [CNT_W-1:0]   cnt;

    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_out_q;
    logic               overflow_q;

    logic               slice_s;
    logic               slice_c;
    logic               op_sub_w;

`ifdef SERIAL_ADD4_SUB_EN
    assign op_sub_w = bus.op_sub;
`else
    assign op_sub_w = 1'b0;
`endif

    add1 u_add1 (
        .a         (a_sr[0]),
        .b         (b_sr[0]),
        .carry_in  (carry_ff),
        .out       (slice_s),
        .carry_out (slice_c)
    );

    // NOTE: every state element uses <= so all updates see pre-edge values;
    // mixing in = here would make shift order depend on statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            carry_ff    <= 1'b0;
            msb_cin     <= 1'b0;
            sub_ff      <= 1'b0;
            cnt         <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sr        <= bus.a;
                        // Subtraction is a + ~b + 1, so only the loaded operand and seed carry change.
                        b_sr        <= op_sub_w ? ~bus.b : bus.b;
                        carry_ff    <= op_sub_w ? 1'b1 : bus.carry_in;
                        sub_ff      <= op_sub_w;
                        cnt         <= '0;
                        sum_q       <= '0;
                        carry_out_q <= 1'b0;
                        overflow_q  <= 1'b0;
                        ready_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        state       <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    sum_q    <= {slice_s, sum_q[WIDTH-1:1]};
                    a_sr     <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr     <= {1'b0, b_sr[WIDTH-1:1]};
                    carry_ff <= slice_c;
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        // Flags are registered here so they are valid alongside done.
                        msb_cin     <= carry_ff;
                        carry_out_q <= slice_c ^ sub_ff;
                        overflow_q  <= carry_ff ^ slice_c;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state       <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end

                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;

endmodule
